// File: rtl/branch_pkg.sv
// Shared types for branch resolution / BTB prediction.
// Holds the funct3 encodings, the 2-bit counter states and the BTB entry view.
// No ports: package only, imported by the branch unit and its table.
package branch_pkg;

  // Widest address the entry view can carry. Narrower XLEN values are zero-extended into it.
  localparam int unsigned MAX_XLEN = 32;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  // 2-bit saturating counter. The MSB is the taken prediction.
  typedef enum logic [1:0] {
    SNT = 2'b00,
    WNT = 2'b01,
    WT  = 2'b10,
    ST  = 2'b11
  } ctr_e;

  // One BTB entry as seen by the resolve/predict logic (tag zero-extended).
  typedef struct packed {
    logic                valid;
    ctr_e                ctr;
    logic [MAX_XLEN-1:0] tag;
    logic [MAX_XLEN-1:0] target;
  } btb_entry_t;

  function automatic ctr_e ctr_inc(input ctr_e c);
    case (c)
      SNT:     return WNT;
      WNT:     return WT;
      default: return ST;
    endcase
  endfunction

  function automatic ctr_e ctr_dec(input ctr_e c);
    case (c)
      ST:      return WT;
      WT:      return WNT;
      default: return SNT;
    endcase
  endfunction

endpackage

// File: rtl/branch_predict_resolve_btb.sv
// Direct-mapped BTB storage: valid flops (sync reset) plus tag/target/ctr arrays.
// Latency: lookup read is combinational; writes land on the rising edge (visible next cycle).
// No backpressure: one write per cycle is always accepted; reset wins over a write.
// Ports: rd_* = fetch lookup port, wr_* = write port, wr_old_* = current contents at wr_idx_i
// (used by the owner to compute the read-modify-write counter update).
module btb_table #(
  parameter int unsigned ENTRIES = 32,
  parameter int unsigned TAG_W   = 25,
  parameter int unsigned XLEN    = 32
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  // lookup port
  input  logic [$clog2(ENTRIES)-1:0]  rd_idx_i,
  output logic                        rd_valid_o,
  output logic [1:0]                  rd_ctr_o,
  output logic [TAG_W-1:0]            rd_tag_o,
  output logic [XLEN-1:0]             rd_target_o,
  // write port
  input  logic                        wr_en_i,
  input  logic [$clog2(ENTRIES)-1:0]  wr_idx_i,
  input  logic [TAG_W-1:0]            wr_tag_i,
  input  logic [XLEN-1:0]             wr_target_i,
  input  logic [1:0]                  wr_ctr_i,
  output logic                        wr_old_valid_o,
  output logic [1:0]                  wr_old_ctr_o,
  output logic [TAG_W-1:0]            wr_old_tag_o,
  output logic [XLEN-1:0]             wr_old_target_o
);

  logic [ENTRIES-1:0] valid_q;
  logic [TAG_W-1:0]   tag_q    [ENTRIES];
  logic [XLEN-1:0]    target_q [ENTRIES];
  logic [1:0]         ctr_q    [ENTRIES];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_q <= '0;
    end else if (wr_en_i) begin
      valid_q[wr_idx_i] <= 1'b1;
    end
  end

  // Payload arrays need no reset: an entry is only observed through its valid bit.
  always_ff @(posedge clk_i) begin
    if (wr_en_i && !rst_i) begin
      tag_q[wr_idx_i]    <= wr_tag_i;
      target_q[wr_idx_i] <= wr_target_i;
      ctr_q[wr_idx_i]    <= wr_ctr_i;
    end
  end

  assign rd_valid_o  = valid_q[rd_idx_i];
  assign rd_ctr_o    = ctr_q[rd_idx_i];
  assign rd_tag_o    = tag_q[rd_idx_i];
  assign rd_target_o = target_q[rd_idx_i];

  assign wr_old_valid_o  = valid_q[wr_idx_i];
  assign wr_old_ctr_o    = ctr_q[wr_idx_i];
  assign wr_old_tag_o    = tag_q[wr_idx_i];
  assign wr_old_target_o = target_q[wr_idx_i];

endmodule

// File: rtl/branch_predict_resolve.sv
// EX-stage branch resolve + BTB predictor: resolves branches/jumps, flags mispredicts, trains BTB.
// Latency: prediction and resolve/redirect are combinational; BTB/counter updates on the next edge.
// No backpressure: one EX instruction per valid cycle is resolved and trained unconditionally.
// Ports: if_pc_i -> pred_*_o (fetch lookup); ex_* + BrEq_i/BrLt_i -> BrUn_o, redirect_*_o,
// illegal_br_o (resolve); branch_cnt_o / mispredict_cnt_o are free-running perf counters.
module branch_predict_resolve
  import branch_pkg::*;
#(
  parameter int unsigned BTB_ENTRIES = 32,
  parameter int unsigned XLEN        = 32
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic [XLEN-1:0] if_pc_i,
  output logic            pred_taken_o,
  output logic [XLEN-1:0] pred_target_o,
  input  logic            ex_valid_i,
  input  logic            ex_is_branch_i,
  input  logic            ex_is_jump_i,
  input  logic [2:0]      ex_funct3_i,
  input  logic [XLEN-1:0] ex_pc_i,
  input  logic [XLEN-1:0] ex_target_i,
  input  logic            ex_pred_taken_i,
  input  logic [XLEN-1:0] ex_pred_target_i,
  input  logic            BrEq_i,
  input  logic            BrLt_i,
  output logic            BrUn_o,
  output logic            redirect_o,
  output logic [XLEN-1:0] redirect_pc_o,
  output logic            illegal_br_o,
  output logic [31:0]     branch_cnt_o,
  output logic [31:0]     mispredict_cnt_o
);

  localparam int unsigned IDX_W = $clog2(BTB_ENTRIES);
  localparam int unsigned TAG_W = XLEN - IDX_W - 2;

  // ---------------- BTB storage ----------------
  logic             rd_valid, old_valid, wr_en;
  logic [1:0]       rd_ctr, old_ctr;
  logic [TAG_W-1:0] rd_tag, old_tag;
  logic [XLEN-1:0]  rd_target, old_target, wr_target;
  ctr_e             wr_ctr;

  logic [IDX_W-1:0] lk_idx, up_idx;
  logic [TAG_W-1:0] lk_tag, up_tag;

  assign lk_idx = if_pc_i[IDX_W+1:2];
  assign lk_tag = if_pc_i[XLEN-1:IDX_W+2];
  assign up_idx = ex_pc_i[IDX_W+1:2];
  assign up_tag = ex_pc_i[XLEN-1:IDX_W+2];

  btb_table #(
    .ENTRIES (BTB_ENTRIES),
    .TAG_W   (TAG_W),
    .XLEN    (XLEN)
  ) u_btb (
    .clk_i           (clk_i),
    .rst_i           (rst_i),
    .rd_idx_i        (lk_idx),
    .rd_valid_o      (rd_valid),
    .rd_ctr_o        (rd_ctr),
    .rd_tag_o        (rd_tag),
    .rd_target_o     (rd_target),
    .wr_en_i         (wr_en),
    .wr_idx_i        (up_idx),
    .wr_tag_i        (up_tag),
    .wr_target_i     (wr_target),
    .wr_ctr_i        (wr_ctr),
    .wr_old_valid_o  (old_valid),
    .wr_old_ctr_o    (old_ctr),
    .wr_old_tag_o    (old_tag),
    .wr_old_target_o (old_target)
  );

  btb_entry_t lk_ent, up_ent;

  always_comb begin
    lk_ent        = '0;
    lk_ent.valid  = rd_valid;
    lk_ent.ctr    = ctr_e'(rd_ctr);
    lk_ent.tag    = MAX_XLEN'(rd_tag);
    lk_ent.target = MAX_XLEN'(rd_target);
    up_ent        = '0;
    up_ent.valid  = old_valid;
    up_ent.ctr    = ctr_e'(old_ctr);
    up_ent.tag    = MAX_XLEN'(old_tag);
    up_ent.target = MAX_XLEN'(old_target);
  end

  // ---------------- Fetch lookup ----------------
  logic lk_hit, up_hit;
  assign lk_hit = lk_ent.valid && (lk_ent.tag == MAX_XLEN'(lk_tag));
  assign up_hit = up_ent.valid && (up_ent.tag == MAX_XLEN'(up_tag));

  assign pred_taken_o  = !rst_i && lk_hit && lk_ent.ctr[1];
  assign pred_target_o = pred_taken_o ? lk_ent.target[XLEN-1:0] : '0;

  // PC byte-offset bits and the counter LSB play no part in lookup.
  logic unused_bits;
  assign unused_bits = ^{if_pc_i[1:0], lk_ent.ctr[0]};

  // ---------------- Resolve ----------------
  logic br_cond, f3_illegal;

  // BLT/BLTU (and BGE/BGEU) share the Lt flag: signedness is chosen in the comparator via BrUn_o.
  always_comb begin
    br_cond    = 1'b0;
    f3_illegal = 1'b0;
    case (ex_funct3_i)
      F3_BEQ:          br_cond = BrEq_i;
      F3_BNE:          br_cond = !BrEq_i;
      F3_BLT, F3_BLTU: br_cond = BrLt_i;
      F3_BGE, F3_BGEU: br_cond = !BrLt_i;
      default:         f3_illegal = 1'b1;
    endcase
  end

  assign BrUn_o = ex_funct3_i[1];

  logic            is_ctrl, is_cond_br, resolving, taken, br_illegal;
  logic            mispredict, stray_pred;
  logic [XLEN-1:0] pc_plus4, actual_next;

  // A jump dominates if decode ever flags both.
  assign is_ctrl     = ex_is_branch_i | ex_is_jump_i;
  assign is_cond_br  = ex_is_branch_i & ~ex_is_jump_i;
  assign resolving   = ex_valid_i & is_ctrl;
  assign taken       = ex_is_jump_i | (is_cond_br & br_cond);
  assign br_illegal  = ex_valid_i & is_cond_br & f3_illegal;
  assign pc_plus4    = ex_pc_i + XLEN'(4);
  assign actual_next = taken ? ex_target_i : pc_plus4;

  assign mispredict = resolving &
                      ((taken != ex_pred_taken_i) |
                       (taken & (ex_pred_target_i != ex_target_i)));
  // Fetch followed a BTB hit on something that is not a control-flow instruction.
  assign stray_pred = ex_valid_i & ~is_ctrl & ex_pred_taken_i;

  assign redirect_o    = !rst_i & (mispredict | stray_pred);
  assign redirect_pc_o = resolving ? actual_next : pc_plus4;
  assign illegal_br_o  = !rst_i & br_illegal;

  // ---------------- BTB update policy ----------------
  always_comb begin
    wr_en     = 1'b0;
    wr_ctr    = WT;
    wr_target = ex_target_i;
    if (!rst_i && resolving && !br_illegal) begin
      if (up_hit) begin
        wr_en  = 1'b1;
        wr_ctr = taken ? ctr_inc(up_ent.ctr) : ctr_dec(up_ent.ctr);
        // Not-taken training keeps the previously learned target.
        wr_target = taken ? ex_target_i : up_ent.target[XLEN-1:0];
      end else if (taken) begin
        wr_en  = 1'b1;
        wr_ctr = ex_is_jump_i ? ST : WT;
      end
    end
  end

  // ---------------- Perf counters ----------------
  logic [31:0] branch_cnt_q, branch_cnt_d;
  logic [31:0] mispredict_cnt_q, mispredict_cnt_d;

  always_comb begin
    branch_cnt_d     = branch_cnt_q;
    mispredict_cnt_d = mispredict_cnt_q;
    if (resolving)  branch_cnt_d     = branch_cnt_q + 32'd1;
    if (redirect_o) mispredict_cnt_d = mispredict_cnt_q + 32'd1;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      branch_cnt_q     <= '0;
      mispredict_cnt_q <= '0;
    end else begin
      branch_cnt_q     <= branch_cnt_d;
      mispredict_cnt_q <= mispredict_cnt_d;
    end
  end

  assign branch_cnt_o     = branch_cnt_q;
  assign mispredict_cnt_o = mispredict_cnt_q;

endmodule

// File: tb/tb_branch_predict_resolve.sv
// Self-checking bench for branch_predict_resolve: directed scenarios then random traffic,
// all outputs compared every cycle against a behavioural BTB/resolve model.
module tb_branch_predict_resolve;

  localparam int N = 32;

  logic        clk;
  logic        rst;
  logic [31:0] if_pc;
  logic        pred_taken;
  logic [31:0] pred_target;
  logic        ex_valid, ex_br, ex_jmp;
  logic [2:0]  ex_f3;
  logic [31:0] ex_pc, ex_tgt, ex_ptgt;
  logic        ex_ptk;
  logic        br_eq, br_lt;
  logic        br_un;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        illegal_br;
  logic [31:0] branch_cnt, mispredict_cnt;

  branch_predict_resolve #(.BTB_ENTRIES(N), .XLEN(32)) dut (
    .clk_i            (clk),
    .rst_i            (rst),
    .if_pc_i          (if_pc),
    .pred_taken_o     (pred_taken),
    .pred_target_o    (pred_target),
    .ex_valid_i       (ex_valid),
    .ex_is_branch_i   (ex_br),
    .ex_is_jump_i     (ex_jmp),
    .ex_funct3_i      (ex_f3),
    .ex_pc_i          (ex_pc),
    .ex_target_i      (ex_tgt),
    .ex_pred_taken_i  (ex_ptk),
    .ex_pred_target_i (ex_ptgt),
    .BrEq_i           (br_eq),
    .BrLt_i           (br_lt),
    .BrUn_o           (br_un),
    .redirect_o       (redirect),
    .redirect_pc_o    (redirect_pc),
    .illegal_br_o     (illegal_br),
    .branch_cnt_o     (branch_cnt),
    .mispredict_cnt_o (mispredict_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  bit          m_v   [N];
  logic [31:0] m_tag [N];
  logic [31:0] m_tgt [N];
  int          m_ctr [N];
  logic [31:0] m_bcnt, m_mcnt;
  bit          e_redirect, e_taken, e_illegal;

  function automatic int idx_of(input logic [31:0] pc);
    return int'((pc / 4) % N);
  endfunction

  function automatic logic [31:0] tag_of(input logic [31:0] pc);
    return pc / (4 * N);
  endfunction

  function automatic bit m_hit(input logic [31:0] pc);
    return m_v[idx_of(pc)] && (m_tag[idx_of(pc)] == tag_of(pc));
  endfunction

  function automatic bit m_cond(input logic [2:0] f3, input bit eq, input bit lt);
    case (f3)
      3'd0:       return eq;
      3'd1:       return !eq;
      3'd4, 3'd6: return lt;
      3'd5, 3'd7: return !lt;
      default:    return 1'b0;
    endcase
  endfunction

  // Combinational expectations, sampled mid-cycle.
  task automatic settle();
    bit          ept, ctrl;
    logic [31:0] enext;
    @(negedge clk);
    ept = !rst && m_hit(if_pc) && (m_ctr[idx_of(if_pc)] >= 2);
    check("pred_taken", pred_taken, ept);
    check("pred_target", pred_target, ept ? m_tgt[idx_of(if_pc)] : 32'h0);
    ctrl      = ex_br || ex_jmp;
    e_taken   = ex_jmp || (ex_br && m_cond(ex_f3, br_eq, br_lt));
    e_illegal = ex_valid && ex_br && !ex_jmp && (ex_f3 == 3'd2 || ex_f3 == 3'd3);
    enext     = e_taken ? ex_tgt : ex_pc + 32'd4;
    if (ctrl)
      e_redirect = ex_valid && ((e_taken != ex_ptk) || (e_taken && ex_ptgt != ex_tgt));
    else
      e_redirect = ex_valid && ex_ptk;
    e_redirect = e_redirect && !rst;
    check("redirect", redirect, e_redirect);
    if (e_redirect) check("redirect_pc", redirect_pc, enext);
    check("illegal_br", illegal_br, e_illegal && !rst);
    check("BrUn", br_un, ex_f3[1]);
    check("branch_cnt", branch_cnt, m_bcnt);
    check("mispredict_cnt", mispredict_cnt, m_mcnt);
  endtask

  // Edge: advance the model with the inputs that were applied this cycle.
  task automatic commit();
    int i;
    @(posedge clk);
    i = idx_of(ex_pc);
    if (rst) begin
      for (int k = 0; k < N; k++) m_v[k] = 1'b0;
      m_bcnt = 0;
      m_mcnt = 0;
    end else begin
      if (ex_valid && (ex_br || ex_jmp)) begin
        m_bcnt++;
        if (!e_illegal) begin
          if (m_hit(ex_pc)) begin
            m_ctr[i] = e_taken ? ((m_ctr[i] == 3) ? 3 : m_ctr[i] + 1)
                               : ((m_ctr[i] == 0) ? 0 : m_ctr[i] - 1);
            if (e_taken) m_tgt[i] = ex_tgt;
          end else if (e_taken) begin
            m_v[i]   = 1'b1;
            m_tag[i] = tag_of(ex_pc);
            m_tgt[i] = ex_tgt;
            m_ctr[i] = ex_jmp ? 3 : 2;
          end
        end
      end
      if (e_redirect) m_mcnt++;
    end
    #1;
  endtask

  task automatic ex_set(input bit v, input bit br, input bit jmp, input logic [2:0] f3,
                        input logic [31:0] pc, input logic [31:0] tgt, input bit ptk,
                        input logic [31:0] ptgt, input bit eq, input bit lt);
    ex_valid = v; ex_br = br; ex_jmp = jmp; ex_f3 = f3;
    ex_pc = pc; ex_tgt = tgt; ex_ptk = ptk; ex_ptgt = ptgt;
    br_eq = eq; br_lt = lt;
  endtask

  task automatic ex_idle();
    ex_set(0, 0, 0, 3'd0, 32'h0, 32'h0, 0, 32'h0, 0, 0);
  endtask

  logic [31:0] pc_pool  [8];
  logic [31:0] tgt_pool [4];
  logic [31:0] mc_before;

  initial begin
    pc_pool  = '{32'h100, 32'h180, 32'h104, 32'h184, 32'h1104, 32'h208, 32'h10C, 32'h7F0};
    tgt_pool = '{32'h140, 32'h240, 32'h200, 32'h500};
    for (int k = 0; k < N; k++) begin
      m_v[k] = 0; m_tag[k] = 0; m_tgt[k] = 0; m_ctr[k] = 0;
    end
    m_bcnt = 0; m_mcnt = 0;
    rst = 1'b1; if_pc = 32'h100;
    ex_idle();
    #1;

    // Reset: outputs forced quiet even with a would-be mispredict on the inputs.
    settle(); commit();
    ex_set(1, 1, 0, 3'd0, 32'h100, 32'h140, 0, 32'h0, 1, 0);
    settle(); check("rst_quiet_redirect", redirect, 0); commit();
    rst = 1'b0;
    ex_idle();
    settle(); check("rst_bcnt_zero", branch_cnt, 0); commit();

    // BEQ at 0x100 taken, predicted not-taken -> redirect, then BTB hit.
    ex_set(1, 1, 0, 3'd0, 32'h100, 32'h140, 0, 32'h0, 1, 0);
    settle(); check("beq_redirect", redirect, 1); check("beq_redirect_pc", redirect_pc, 32'h140);
    commit();
    ex_idle();
    settle(); check("beq_lookup_taken", pred_taken, 1); check("beq_lookup_tgt", pred_target, 32'h140);
    commit();

    // BLTU taken (unsigned select), BGE with Lt=1 not taken.
    ex_set(1, 1, 0, 3'd6, 32'h110, 32'h180, 0, 32'h0, 0, 1);
    settle(); check("bltu_brun", br_un, 1); check("bltu_redirect", redirect, 1); commit();
    ex_set(1, 1, 0, 3'd5, 32'h114, 32'h180, 0, 32'h0, 0, 1);
    settle(); check("bge_brun", br_un, 0); check("bge_no_redirect", redirect, 0); commit();
    ex_set(1, 1, 0, 3'd5, 32'h118, 32'h180, 1, 32'h180, 0, 1);
    settle(); check("bge_pred_redirect", redirect, 1); check("bge_pred_pc", redirect_pc, 32'h11C);
    commit();

    // Hysteresis on BNE at 0x124: T,T,T,NT -> still taken; NT -> not taken.
    if_pc = 32'h124;
    ex_set(1, 1, 0, 3'd1, 32'h124, 32'h400, 0, 32'h0, 0, 0); settle(); commit();
    ex_set(1, 1, 0, 3'd1, 32'h124, 32'h400, 1, 32'h400, 0, 0); settle(); commit();
    ex_set(1, 1, 0, 3'd1, 32'h124, 32'h400, 1, 32'h400, 0, 0); settle(); commit();
    ex_set(1, 1, 0, 3'd1, 32'h124, 32'h400, 1, 32'h400, 1, 0); settle(); commit();
    ex_set(1, 1, 0, 3'd1, 32'h124, 32'h400, 1, 32'h400, 1, 0);
    settle(); check("hyst_still_taken", pred_taken, 1); commit();
    ex_idle();
    settle(); check("hyst_now_not_taken", pred_taken, 0); commit();

    // Target mismatch: predicted 0x200, actual 0x240.
    mc_before = m_mcnt;
    ex_set(1, 1, 0, 3'd0, 32'h208, 32'h240, 1, 32'h200, 1, 0);
    settle(); check("tm_redirect_pc", redirect_pc, 32'h240); commit();
    ex_idle(); if_pc = 32'h208;
    settle(); check("tm_mcnt", mispredict_cnt, mc_before + 1); check("tm_new_tgt", pred_target, 32'h240);
    commit();

    // Aliasing: 0x180 replaces 0x100 in index 0; same-cycle lookup sees the old entry.
    if_pc = 32'h100;
    ex_set(1, 1, 0, 3'd0, 32'h180, 32'h500, 0, 32'h0, 1, 0);
    settle(); check("alias_same_cycle_taken", pred_taken, 1); check("alias_same_cycle_tgt", pred_target, 32'h140);
    commit();
    ex_idle();
    settle(); check("alias_old_misses", pred_taken, 0); commit();

    // Illegal funct3 on a hit entry leaves it untouched.
    if_pc = 32'h10C;
    ex_set(1, 1, 0, 3'd0, 32'h10C, 32'h600, 0, 32'h0, 1, 0); settle(); commit();
    ex_set(1, 1, 0, 3'd3, 32'h10C, 32'h600, 0, 32'h0, 1, 1);
    settle(); check("illegal_flag", illegal_br, 1); commit();
    ex_set(1, 1, 0, 3'd2, 32'h10C, 32'h600, 0, 32'h0, 1, 1); settle(); commit();
    ex_idle();
    settle(); check("illegal_no_update", pred_taken, 1); commit();

    // Mid-stream reset during a valid mispredict.
    rst = 1'b1;
    ex_set(1, 1, 0, 3'd0, 32'h130, 32'h700, 0, 32'h0, 1, 0);
    settle(); check("mid_rst_redirect", redirect, 0); commit();
    rst = 1'b0; ex_idle(); if_pc = 32'h100;
    settle(); check("mid_rst_bcnt", branch_cnt, 0); check("mid_rst_mcnt", mispredict_cnt, 0);
    check("mid_rst_btb_empty", pred_taken, 0);
    commit();

    // Random traffic over a small aliasing PC pool.
    for (int c = 0; c < 1500; c++) begin
      int          kind;
      logic [31:0] pc;
      rst   = ($urandom_range(0, 59) == 0);
      if_pc = pc_pool[$urandom_range(0, 7)];
      pc    = pc_pool[$urandom_range(0, 7)];
      kind  = $urandom_range(0, 3);
      ex_set($urandom_range(0, 7) != 0, kind == 1 || kind == 2, kind == 3,
             3'($urandom_range(0, 7)), pc, tgt_pool[$urandom_range(0, 3)],
             $urandom_range(0, 1), tgt_pool[$urandom_range(0, 3)],
             $urandom_range(0, 1), $urandom_range(0, 1));
      if ($urandom_range(0, 9) < 6) begin
        ex_ptk  = m_hit(pc) && (m_ctr[idx_of(pc)] >= 2);
        ex_ptgt = ex_ptk ? m_tgt[idx_of(pc)] : 32'h0;
      end
      settle();
      commit();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
